pipe_issue: RTL and testbench

PIPE_ISSUE -- requirements
Module: pipe_issue

---
 rtl/pipe_issue.sv | 129 ++++++++++++
 tb/tb_pipe_issue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue.sv
// In-order issue stage: instruction FIFO feeding the ALU with a RAW hazard check against the last HAZ_DEPTH issues.
// Optional macro PIPE_ISSUE_HAZARD_STALL_EN enables the hazard stall; FIFO-to-instr latency is 1 cycle; in_ready drops at DEPTH entries.
module pipe_issue #(
  parameter int DEPTH     = 4,
  parameter int HAZ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
`ifdef PIPE_ISSUE_HAZARD_STALL_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_EMPTY, S_ISSUE, S_STALL} state_t;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [15:0]   instr_q;
  logic          instr_valid_q;
  logic [15:0]   stall_cnt_q;
  logic          hv_q  [HAZ_DEPTH];
  logic [3:0]    hrd_q [HAZ_DEPTH];

  logic          legal, push, pop, hazard_raw, hazard;
  logic [15:0]   head;
  state_t        state;

  always_comb begin
    legal = 1'b0;
    case (in_instr[15:12])
      4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready && legal;
  assign head     = mem_q[rd_ptr_q];

  // Bubbles leave invalid history slots, so they never match.
  always_comb begin
    hazard_raw = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (hv_q[i] && (hrd_q[i] == head[11:8] || hrd_q[i] == head[7:4]))
        hazard_raw = 1'b1;
    end
  end

  assign hazard = HAZ_EN && hazard_raw;

  always_comb begin
    if (count_q == '0)  state = S_EMPTY;
    else if (hazard)    state = S_STALL;
    else                state = S_ISSUE;
  end

  assign pop = (state == S_ISSUE);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      instr_q       <= 16'h0000;
      instr_valid_q <= 1'b0;
      stall_cnt_q   <= 16'h0000;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        hv_q[i]  <= 1'b0;
        hrd_q[i] <= 4'h0;
      end
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
        hv_q[i]  <= hv_q[i-1];
        hrd_q[i] <= hrd_q[i-1];
      end

      case (state)
        S_ISSUE: begin
          rd_ptr_q      <= rd_ptr_q + 1'b1;
          instr_q       <= head;
          instr_valid_q <= 1'b1;
          hv_q[0]       <= 1'b1;
          hrd_q[0]      <= head[3:0];
        end
        S_STALL: begin
          instr_q       <= 16'h0000;
          instr_valid_q <= 1'b0;
          hv_q[0]       <= 1'b0;
          hrd_q[0]      <= 4'h0;
          if (stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
        default: begin
          instr_q       <= 16'h0000;
          instr_valid_q <= 1'b0;
          hv_q[0]       <= 1'b0;
          hrd_q[0]      <= 4'h0;
        end
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_issue.sv
// Directed bench for pipe_issue; expectations follow PIPE_ISSUE_HAZARD_STALL_EN.
module tb_pipe_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] stall_cnt;

  int passed = 0;
  int total  = 0;
  int exp_stall;

  logic [15:0] c_drv [9];
  logic        c_dv  [9];
  logic [15:0] c_ei  [9];
  logic        c_ev  [9];
  logic        c_er  [9];
  int          c_ne;
  int          c_stall;

  pipe_issue #(.DEPTH(4), .HAZ_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_instr    (in_instr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic out3(input string tag, input logic [15:0] ei, input logic ev, input logic er);
    chk({tag, " instr"}, instr, ei);
    chk({tag, " instr_valid"}, {15'd0, instr_valid}, {15'd0, ev});
    chk({tag, " in_ready"}, {15'd0, in_ready}, {15'd0, er});
  endtask

  initial begin
`ifdef PIPE_ISSUE_HAZARD_STALL_EN
    // Dependent chain: each instruction reads the previous rd, so the FIFO fills.
    c_ne    = 9;
    c_stall = 5;
    c_drv = '{16'h201F, 16'h6F1E, 16'h2E0D, 16'h2D0C, 16'h2C0B, 16'h2B0A, 16'h2A09, 16'h2A09, 16'h2A09};
    c_dv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    c_ei  = '{16'h0000, 16'h201F, 16'h0000, 16'h0000, 16'h6F1E, 16'h0000, 16'h0000, 16'h2E0D, 16'h0000};
    c_ev  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    c_er  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    c_ne    = 7;
    c_stall = 0;
    c_drv = '{16'h201F, 16'h6F1E, 16'h2E0D, 16'h2D0C, 16'h2C0B, 16'h2B0A, 16'h2A09, 16'h0000, 16'h0000};
    c_dv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    c_ei  = '{16'h0000, 16'h201F, 16'h6F1E, 16'h2E0D, 16'h2D0C, 16'h2C0B, 16'h2B0A, 16'h0000, 16'h0000};
    c_ev  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    c_er  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset state
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = 16'h0000;
    #2;
    out3("reset", 16'h0000, 1'b0, 1'b1);
    chk("reset stall_cnt", stall_cnt, 16'h0000);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick;

    // RAW dependency 0x201F -> 0x6F1E
    in_valid = 1'b1;
    in_instr = 16'h201F;
    tick;
    chk("A1 instr_valid", {15'd0, instr_valid}, 16'h0000);
    in_instr = 16'h6F1E;
    tick;
    in_valid = 1'b0;
    out3("A2", 16'h201F, 1'b1, 1'b1);
`ifdef PIPE_ISSUE_HAZARD_STALL_EN
    exp_stall = 2;
    tick;
    out3("A3 bubble", 16'h0000, 1'b0, 1'b1);
    tick;
    out3("A4 bubble", 16'h0000, 1'b0, 1'b1);
    tick;
    out3("A5", 16'h6F1E, 1'b1, 1'b1);
    chk("A5 stall_cnt", stall_cnt, 16'(exp_stall));
    tick;
    out3("A6 empty", 16'h0000, 1'b0, 1'b1);
`else
    exp_stall = 0;
    tick;
    out3("A3", 16'h6F1E, 1'b1, 1'b1);
    tick;
    out3("A4 empty", 16'h0000, 1'b0, 1'b1);
`endif
    chk("A stall_cnt", stall_cnt, 16'(exp_stall));
    repeat (3) tick;

    // Independent instructions issue back-to-back
    in_valid = 1'b1;
    in_instr = 16'h201F;
    tick;
    in_instr = 16'h001E;
    tick;
    out3("B1", 16'h201F, 1'b1, 1'b1);
    in_instr = 16'h101D;
    tick;
    in_valid = 1'b0;
    out3("B2", 16'h001E, 1'b1, 1'b1);
    tick;
    out3("B3", 16'h101D, 1'b1, 1'b1);
    tick;
    out3("B4 empty", 16'h0000, 1'b0, 1'b1);
    chk("B stall_cnt", stall_cnt, 16'(exp_stall));
    repeat (2) tick;

    // Illegal opcode dropped at acceptance
    in_valid = 1'b1;
    in_instr = 16'h3012;
    tick;
    out3("D1", 16'h0000, 1'b0, 1'b1);
    in_instr = 16'h201F;
    tick;
    in_valid = 1'b0;
    out3("D2 no illegal issue", 16'h0000, 1'b0, 1'b1);
    tick;
    out3("D3", 16'h201F, 1'b1, 1'b1);
    tick;
    out3("D4 empty", 16'h0000, 1'b0, 1'b1);
    repeat (3) tick;

    // Streaming with in_valid held high; FIFO fill and backpressure when stalling
    for (int e = 0; e < c_ne; e++) begin
      in_valid = c_dv[e];
      in_instr = c_drv[e];
      tick;
      out3($sformatf("C%0d", e + 1), c_ei[e], c_ev[e], c_er[e]);
    end
    in_valid = 1'b0;
    exp_stall = exp_stall + c_stall;
    chk("C stall_cnt", stall_cnt, 16'(exp_stall));

    // Mid-operation reset with instructions still queued
    #2 rst_n = 1'b0;
    #1;
    exp_stall = 0;
    out3("R reset", 16'h0000, 1'b0, 1'b1);
    chk("R stall_cnt", stall_cnt, 16'(exp_stall));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      out3($sformatf("R idle%0d", k), 16'h0000, 1'b0, 1'b1);
    end

    // First push after reset is accepted on the first edge
    in_valid = 1'b1;
    in_instr = 16'h201F;
    tick;
    in_valid = 1'b0;
    out3("P1", 16'h0000, 1'b0, 1'b1);
    tick;
    out3("P2", 16'h201F, 1'b1, 1'b1);
    chk("P stall_cnt", stall_cnt, 16'(exp_stall));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
